// File: rtl/inst_mem_if.sv
// Fetch-address/instruction bus plus the byte-serial program loader port.
// The master side is the fetch stage and loader source; the slave side is inst_mem.
interface inst_mem_if #(
   parameter int AW    = 32,
   parameter int IW    = 32,
   parameter int DEPTH = 1024
) ();
   localparam int LW = $clog2(DEPTH) + 1;

   logic [AW-1:0] inst_addr;
   logic [IW-1:0] inst_out;
   logic          inst_misalign;
   logic          ld_start;
   logic [LW-1:0] ld_words;
   logic          ld_valid;
   logic [7:0]    ld_byte;
   logic          ld_ready;
   logic          ld_done;
   logic          ld_err;
   logic          cpu_hold;

   modport master (
      output inst_addr, ld_start, ld_words, ld_valid, ld_byte,
      input  inst_out, inst_misalign, ld_ready, ld_done, ld_err, cpu_hold
   );

   modport slave (
      input  inst_addr, ld_start, ld_words, ld_valid, ld_byte,
      output inst_out, inst_misalign, ld_ready, ld_done, ld_err, cpu_hold
   );
endinterface

// File: rtl/inst_mem.sv
// Word-organised instruction memory with combinational fetch and a byte-serial loader.
// Optional macro IMEM_ALIGN_CHECK_EN flags misaligned fetches and returns NOP for them.
module inst_mem #(
   parameter int           AW    = 32,
   parameter int           IW    = 32,
   parameter int           DEPTH = 1024,
   parameter logic [IW-1:0] NOP  = 32'h0000_0013
) (
   input logic      clk,
   input logic      rst,
   inst_mem_if.slave bus
);
   localparam int IX = $clog2(DEPTH);
   localparam int LW = IX + 1;
   localparam logic [AW-1:0] LIMIT = AW'(4 * DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t        state_q;
   logic [LW-1:0] wordCnt_q;
   logic [LW-1:0] count_q;
   logic [1:0]    byteCnt_q;
   logic [23:0]   asm_q;
   logic          ldErr_q;

   logic [IW-1:0] mem [DEPTH];

   logic [LW-1:0] wordCnt_d;
   logic          startOk;
   logic          byteTake;
   logic          wordWe;

   assign wordCnt_d = wordCnt_q + LW'(1);
   assign startOk   = bus.ld_start && (state_q != DONE);
   assign byteTake  = (state_q == LOAD) && !bus.ld_start && bus.ld_valid;
   assign wordWe    = byteTake && (byteCnt_q == 2'd3);

   // Loader FSM: a start (from IDLE or as a restart in LOAD) wins over any byte in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         wordCnt_q <= '0;
         count_q   <= '0;
         byteCnt_q <= '0;
         asm_q     <= '0;
         ldErr_q   <= 1'b0;
      end else if (startOk) begin
         if (bus.ld_words > LW'(DEPTH)) begin
            ldErr_q <= 1'b1;
            state_q <= IDLE;
         end else if (bus.ld_words == '0) begin
            ldErr_q <= 1'b0;
            state_q <= DONE;
         end else begin
            ldErr_q   <= 1'b0;
            count_q   <= bus.ld_words;
            wordCnt_q <= '0;
            byteCnt_q <= '0;
            asm_q     <= '0;
            state_q   <= LOAD;
         end
      end else if (byteTake) begin
         case (byteCnt_q)
            2'd0:    asm_q[7:0]   <= bus.ld_byte;
            2'd1:    asm_q[15:8]  <= bus.ld_byte;
            2'd2:    asm_q[23:16] <= bus.ld_byte;
            default: asm_q        <= asm_q;
         endcase
         byteCnt_q <= byteCnt_q + 2'd1;
         if (byteCnt_q == 2'd3) begin
            wordCnt_q <= wordCnt_d;
            if (wordCnt_d == count_q) state_q <= DONE;
         end
      end else if (state_q == DONE) begin
         state_q <= IDLE;
      end
   end

   // Array has no reset so it maps onto plain RAM; contents survive a reset.
   always_ff @(posedge clk) begin
      if (wordWe) mem[wordCnt_q[IX-1:0]] <= {bus.ld_byte, asm_q};
   end

   assign bus.ld_ready = (state_q == LOAD);
   assign bus.ld_done  = (state_q == DONE);
   assign bus.ld_err   = ldErr_q;
   assign bus.cpu_hold = (state_q != IDLE);

`ifdef IMEM_ALIGN_CHECK_EN
   assign bus.inst_misalign = |bus.inst_addr[1:0];
`else
   logic unusedAddrLow;
   assign unusedAddrLow     = ^bus.inst_addr[1:0];
   assign bus.inst_misalign = 1'b0;
`endif

   // Fetch never stalls: anything not safely readable returns NOP instead.
   always_comb begin
      bus.inst_out = NOP;
      if ((state_q == IDLE) && (bus.inst_addr < LIMIT) && !bus.inst_misalign)
         bus.inst_out = mem[bus.inst_addr[IX+1:2]];
   end
endmodule

// File: tb/tb_inst_mem.sv
// Directed self-checking bench for inst_mem using a small 16-word array.
// Expected values are hand-computed from the loader byte sequences below.
module tb_inst_mem;
   localparam int DEPTH = 16;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk;
   logic rst;
   int   nTests;
   int   nFail;

   inst_mem_if #(.AW(32), .IW(32), .DEPTH(DEPTH)) bus ();

   inst_mem #(.AW(32), .IW(32), .DEPTH(DEPTH), .NOP(NOP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic start, input logic [4:0] words,
                                input logic valid, input logic [7:0] b);
      bus.ld_start = start;
      bus.ld_words = words;
      bus.ld_valid = valid;
      bus.ld_byte  = b;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      #1;
      nTests++;
      assert (observed === expected)
      else begin
         nFail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic readWord(input string tag, input logic [31:0] addr,
                           input logic [31:0] expected);
      bus.inst_addr = addr;
      #1;
      checkOutput(tag, bus.inst_out, expected);
   endtask

   // Sends one byte per call; a gap cycle is a call with valid low.
   task automatic sendByte(input logic valid, input logic [7:0] b);
      applyStimulus(1'b0, 5'd0, valid, b);
      tick();
   endtask

   initial begin
      nTests = 0;
      nFail  = 0;
      bus.inst_addr = 32'h0;
      applyStimulus(1'b0, 5'd0, 1'b0, 8'h00);

      rst = 1'b1;
      tick();
      tick();
      checkOutput("rst_ready", {31'b0, bus.ld_ready}, 32'd0);
      checkOutput("rst_done", {31'b0, bus.ld_done}, 32'd0);
      checkOutput("rst_err", {31'b0, bus.ld_err}, 32'd0);
      checkOutput("rst_hold", {31'b0, bus.cpu_hold}, 32'd0);
      checkOutput("rst_misalign", {31'b0, bus.inst_misalign}, 32'd0);
      rst = 1'b0;

      // Two-word load, start in cycle 0, ld_done expected in cycle 9
      applyStimulus(1'b1, 5'd2, 1'b0, 8'h00);
      tick();
      applyStimulus(1'b0, 5'd0, 1'b1, 8'h13);
      checkOutput("load_hold_c1", {31'b0, bus.cpu_hold}, 32'd1);
      checkOutput("load_ready_c1", {31'b0, bus.ld_ready}, 32'd1);
      readWord("load_blocked_read", 32'h0, NOP);
      tick();
      sendByte(1'b1, 8'h00);
      sendByte(1'b1, 8'h00);
      sendByte(1'b1, 8'h00);
      sendByte(1'b1, 8'h93);
      sendByte(1'b1, 8'h00);
      sendByte(1'b1, 8'h10);
      checkOutput("load_done_c8", {31'b0, bus.ld_done}, 32'd0);
      sendByte(1'b1, 8'h00);
      applyStimulus(1'b0, 5'd0, 1'b0, 8'h00);
      checkOutput("load_done_c9", {31'b0, bus.ld_done}, 32'd1);
      checkOutput("load_hold_c9", {31'b0, bus.cpu_hold}, 32'd1);
      checkOutput("load_ready_c9", {31'b0, bus.ld_ready}, 32'd0);
      tick();
      checkOutput("load_done_c10", {31'b0, bus.ld_done}, 32'd0);
      checkOutput("load_hold_c10", {31'b0, bus.cpu_hold}, 32'd0);
      readWord("read_word0", 32'h0, 32'h0000_0013);
      readWord("read_word1", 32'h4, 32'h0010_0093);
      readWord("read_unmapped", 32'(4 * DEPTH), NOP);

      // Rejected start, then a valid start clears the error
      applyStimulus(1'b1, 5'(DEPTH + 1), 1'b0, 8'h00);
      tick();
      applyStimulus(1'b0, 5'd0, 1'b0, 8'h00);
      checkOutput("rej_err", {31'b0, bus.ld_err}, 32'd1);
      checkOutput("rej_ready", {31'b0, bus.ld_ready}, 32'd0);
      checkOutput("rej_hold", {31'b0, bus.cpu_hold}, 32'd0);
      tick();
      checkOutput("rej_ready_later", {31'b0, bus.ld_ready}, 32'd0);

      // Restart: 4-word load, five bytes, then restart with one word plus a dropped byte
      applyStimulus(1'b1, 5'd4, 1'b0, 8'h00);
      tick();
      checkOutput("restart_err_clr", {31'b0, bus.ld_err}, 32'd0);
      sendByte(1'b1, 8'h11);
      sendByte(1'b1, 8'h22);
      sendByte(1'b1, 8'h33);
      sendByte(1'b1, 8'h44);
      sendByte(1'b1, 8'h55);
      applyStimulus(1'b1, 5'd1, 1'b1, 8'h99);
      tick();
      readWord("restart_blocked", 32'h4, NOP);
      sendByte(1'b1, 8'hAA);
      sendByte(1'b0, 8'hEE);
      sendByte(1'b1, 8'hBB);
      sendByte(1'b1, 8'hCC);
      sendByte(1'b0, 8'hEE);
      checkOutput("restart_not_done", {31'b0, bus.ld_done}, 32'd0);
      sendByte(1'b1, 8'hDD);
      applyStimulus(1'b0, 5'd0, 1'b0, 8'h00);
      checkOutput("restart_done", {31'b0, bus.ld_done}, 32'd1);
      tick();
      readWord("restart_word0", 32'h0, 32'hDDCC_BBAA);
      readWord("restart_word1", 32'h4, 32'h0010_0093);

      // Zero-word load completes on the next cycle
      applyStimulus(1'b1, 5'd0, 1'b0, 8'h00);
      tick();
      applyStimulus(1'b0, 5'd0, 1'b0, 8'h00);
      checkOutput("zero_done", {31'b0, bus.ld_done}, 32'd1);
      checkOutput("zero_hold", {31'b0, bus.cpu_hold}, 32'd1);
      tick();
      checkOutput("zero_idle", {31'b0, bus.cpu_hold}, 32'd0);

      // Out-of-range restart during LOAD sets the error and drops back to IDLE
      applyStimulus(1'b1, 5'd2, 1'b0, 8'h00);
      tick();
      applyStimulus(1'b1, 5'd20, 1'b0, 8'h00);
      tick();
      applyStimulus(1'b0, 5'd0, 1'b0, 8'h00);
      checkOutput("rej_load_err", {31'b0, bus.ld_err}, 32'd1);
      checkOutput("rej_load_hold", {31'b0, bus.cpu_hold}, 32'd0);

      // Reset mid-load keeps the first full word, loses the partial second
      applyStimulus(1'b1, 5'd2, 1'b0, 8'h00);
      tick();
      sendByte(1'b1, 8'h01);
      sendByte(1'b1, 8'h02);
      sendByte(1'b1, 8'h03);
      sendByte(1'b1, 8'h04);
      sendByte(1'b1, 8'h05);
      sendByte(1'b1, 8'h06);
      applyStimulus(1'b0, 5'd0, 1'b0, 8'h00);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("rstmid_hold", {31'b0, bus.cpu_hold}, 32'd0);
      checkOutput("rstmid_ready", {31'b0, bus.ld_ready}, 32'd0);
      checkOutput("rstmid_err", {31'b0, bus.ld_err}, 32'd0);
      readWord("rstmid_word0", 32'h0, 32'h0403_0201);
      readWord("rstmid_word1", 32'h4, 32'h0010_0093);

      bus.inst_addr = 32'h6;
`ifdef IMEM_ALIGN_CHECK_EN
      checkOutput("misalign_flag", {31'b0, bus.inst_misalign}, 32'd1);
      checkOutput("misalign_out", bus.inst_out, NOP);
`else
      checkOutput("misalign_flag", {31'b0, bus.inst_misalign}, 32'd0);
      checkOutput("misalign_out", bus.inst_out, 32'h0010_0093);
`endif

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule

// File: doc/inst_mem.md
# inst_mem

Word-organised instruction memory: the responder on the fetch-address/instruction interface driven by the pipeline's fetch stage. It returns the instruction at the presented byte address combinationally, in the same cycle. It also contains a byte-serial program loader that fills the array at run time and holds the core while loading. The fetch stage presents `inst_addr` and consumes `inst_out` without a handshake, so this block never stalls a read.

## Interface
- `DEPTH`, default 1024: number of 32-bit words; power of two, ≥ 4.
- `NOP`, default 32'h0000_0013: word returned for unmapped, blocked or misaligned reads.

Ports (widths from `cpu_property.v`; AW = `INST_ADDR_WIDTH`, IW = `INST_WIDTH`, LW = $clog2(DEPTH)+1):
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `inst_addr` in AW: fetch byte address.
- `inst_out` out IW: instruction at `inst_addr`.
- `inst_misalign` out 1: `inst_addr[1:0]` nonzero (see Configuration).
- `ld_start` in 1: one-cycle pulse that begins a load.
- `ld_words` in LW: word count, sampled when `ld_start` is high.
- `ld_valid` in 1: loader byte valid.
- `ld_byte` in 8: loader byte.
- `ld_ready` out 1: loader can accept a byte.
- `ld_done` out 1: one-cycle pulse when a load completes.
- `ld_err` out 1: sticky flag; the last `ld_start` was rejected.
- `cpu_hold` out 1: core must stall or hold in reset.

## Operation
- **States:** IDLE, LOAD, DONE.
- **Reset values:** state IDLE, word counter 0, byte counter 0, assembly register 0. All outputs 0 except `inst_out`, which is combinational. The memory array is not cleared.
- **Read path:**
  - Index = `inst_addr[$clog2(DEPTH)+1:2]`.
  - `inst_out` = mem[index] in IDLE.
  - `inst_out` = `NOP` if `inst_addr` ≥ 4·DEPTH, or if the state is LOAD or DONE.
- **IDLE:**
  - If `ld_start` and `ld_words` > DEPTH: set `ld_err` and stay in IDLE.
  - If `ld_start` and `ld_words` == 0: clear `ld_err` and go to DONE.
  - If `ld_start` otherwise: clear `ld_err`, latch `ld_words`, zero both counters, go to LOAD.
- **LOAD:**
  - `ld_ready` = 1.
  - A byte is accepted when `ld_valid && ld_ready`.
  - Bytes are assembled little-endian: the first byte goes to bits [7:0] and the fourth to bits [31:24].
  - On the edge that accepts the fourth byte, the word is written to mem[word counter], the word counter increments and the byte counter wraps to 0.
  - When the incremented word counter equals the latched count, go to DONE.
- **DONE:** `ld_done` = 1 for exactly one cycle, then go to IDLE.
- **Hold:** `cpu_hold` = 1 in LOAD and DONE, 0 in IDLE.
- **`ld_start` during LOAD:** restarts the load. The new `ld_words` is re-checked, counters and the partial word are discarded, and words already written remain. An out-of-range count sets `ld_err` and returns to IDLE.
- **`ld_start` during DONE:** ignored.
- **`ld_start` with `ld_valid` in the same cycle in LOAD:** the restart wins and the byte is dropped.
- **Reset mid-load:** go to IDLE. The partial word is lost and written words are kept.

## Timing
- Read latency is 0 cycles (combinational from `inst_addr` and state).
- A word written at edge N is readable in IDLE from cycle N+1 onward. A write to the currently addressed word is not forwarded within the same cycle.
- `ld_ready` rises the cycle after the accepted `ld_start`. The loader's maximum rate is one byte per cycle.
- For a load of n ≥ 1 words with `ld_valid` held high:
  - `ld_start` at cycle 0, LOAD from cycle 1.
  - The last byte is accepted at the end of cycle 4n.
  - `ld_done` and DONE occur in cycle 4n+1.
  - `cpu_hold` falls at cycle 4n+2.
- For n = 0: `ld_done` occurs in cycle 1.

## Configuration
- **Macro `IMEM_ALIGN_CHECK_EN`.**
- **Defined:**
  - `inst_misalign` = |`inst_addr[1:0]`.
  - When `inst_misalign` is 1, `inst_out` = `NOP` regardless of state.
- **Undefined:**
  - `inst_misalign` is tied to 0.
  - `inst_addr[1:0]` is ignored, so the read uses the word index only.

## Test plan
- **Reset then read:** assert `rst`, read any address → all outputs 0 except `inst_out`; state IDLE.
- **Two-word load:** `ld_start` with `ld_words`=2, then bytes 13,00,00,00,93,00,10,00 → `ld_done` at cycle 9; after it, address 0 reads 32'h00000013 and address 4 reads 32'h00100093; `cpu_hold` high for cycles 1–9.
- **Rejected load:** `ld_start` with `ld_words`=DEPTH+1 → `ld_err`=1, `ld_ready` stays 0; a following valid start clears `ld_err`.
- **Restart and stalled source:** start a 4-word load and send 5 bytes, then pulse `ld_start` with `ld_words`=1 → word 0 is overwritten by the next 4 bytes, `ld_done` follows; insert `ld_valid` gaps → byte order is preserved.
- **Unmapped and blocked reads:** read `inst_addr`=4·DEPTH → `NOP`; read during LOAD → `NOP`; assert `rst` mid-load → IDLE, `cpu_hold`=0, earlier full words intact.
- **Misaligned read:** with `IMEM_ALIGN_CHECK_EN` defined, read `inst_addr`=32'h6 → `inst_misalign`=1, `inst_out`=`NOP`; without the macro → `inst_misalign`=0 and `inst_out`=mem[1].
